// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the PhilosophyV datapath.
// Steps FETCH/DECODE/EXECUTE/MEM/WB, owns the shared memory port through a
// req/ready handshake with a timeout, halts on faults and counts retirements.
// Moore strobes are registered from the next state; only ir_we/pc_we and the
// store retire pulse look at mem_ready combinationally.
module multicycle_ctrl #(
  parameter int IC_W    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      opcode,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            ir_we,
  output logic            pc_we,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            alu_src_b,
  output logic            controlOverride,
  output logic            retire,
  output logic [IC_W-1:0] instret,
  output logic            halted,
  output logic [1:0]      fault,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;

  // A zero TIMEOUT still needs a 1-bit counter so the logic elaborates.
  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_ALU_REG, OP_ALU_IMM, OP_LOAD, OP_STORE: ok = 1'b1;
      default:                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  state_e          state_q, state_d;
  logic [6:0]      op_q, op_d;
  logic [1:0]      fault_q, fault_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IC_W-1:0] instret_q;
  logic            to_hit_s;
  logic            retire_s;

  logic mem_req_q, mem_we_q, mem_addr_sel_q, rf_we_q, wb_sel_q;
  logic alu_src_b_q, ctrl_ovr_q, wb_ret_q, halted_q;
  logic mem_req_d, mem_we_d, mem_addr_sel_d, rf_we_d, wb_sel_d;
  logic alu_src_b_d, ctrl_ovr_d, wb_ret_d, halted_d;

  assign to_hit_s = TO_EN && (cnt_q == TO_LAST);

  // Next-state, opcode latch, fault capture and request-timeout counting.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (to_hit_s) begin
          state_d = S_HALT;
          fault_d = 2'd2;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (is_legal(opcode)) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_HALT;
          fault_d = 2'd1;
        end
      end
      S_EXECUTE: begin
        if (is_mem_op(op_q)) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit_s) begin
          state_d = S_HALT;
          fault_d = 2'd2;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Moore strobes for the state being entered, so they are flop outputs.
  always_comb begin
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_sel_d = 1'b0;
    rf_we_d        = 1'b0;
    wb_sel_d       = 1'b0;
    alu_src_b_d    = 1'b0;
    ctrl_ovr_d     = 1'b0;
    wb_ret_d       = 1'b0;
    halted_d       = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_req_d = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_b_d = (op_d != OP_ALU_REG);
        ctrl_ovr_d  = is_mem_op(op_d);
      end
      S_MEM: begin
        mem_req_d      = 1'b1;
        mem_addr_sel_d = 1'b1;
        mem_we_d       = (op_d == OP_STORE);
        ctrl_ovr_d     = 1'b1;
        alu_src_b_d    = 1'b1;
      end
      S_WB: begin
        rf_we_d  = 1'b1;
        wb_sel_d = (op_d == OP_LOAD);
        wb_ret_d = 1'b1;
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        halted_d = 1'b0;
      end
    endcase
  end

  // A store retires in its MEM ready cycle; everything else retires in WB.
  assign retire_s = wb_ret_q ||
                    ((state_q == S_MEM) && (op_q == OP_STORE) && mem_ready);

  // State, opcode, fault, timeout counter, registered strobes, retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RST;
      op_q           <= 7'd0;
      fault_q        <= 2'd0;
      cnt_q          <= '0;
      instret_q      <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_sel_q <= 1'b0;
      rf_we_q        <= 1'b0;
      wb_sel_q       <= 1'b0;
      alu_src_b_q    <= 1'b0;
      ctrl_ovr_q     <= 1'b0;
      wb_ret_q       <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      fault_q        <= fault_d;
      cnt_q          <= cnt_d;
      instret_q      <= retire_s ? instret_q + IC_W'(1) : instret_q;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_sel_q <= mem_addr_sel_d;
      rf_we_q        <= rf_we_d;
      wb_sel_q       <= wb_sel_d;
      alu_src_b_q    <= alu_src_b_d;
      ctrl_ovr_q     <= ctrl_ovr_d;
      wb_ret_q       <= wb_ret_d;
      halted_q       <= halted_d;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr_sel    = mem_addr_sel_q;
  assign ir_we           = (state_q == S_FETCH) && mem_ready;
  assign pc_we           = (state_q == S_FETCH) && mem_ready;
  assign rf_we           = rf_we_q;
  assign wb_sel          = wb_sel_q;
  assign alu_src_b       = alu_src_b_q;
  assign controlOverride = ctrl_ovr_q;
  assign retire          = retire_s;
  assign instret         = instret_q;
  assign halted          = halted_q;
  assign fault           = fault_q;
  assign state           = state_q;

endmodule
